dcache_ctrl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache. Sits between the ALU and main memory.
//  The ALU result is the load/store byte address; read hits return data the same cycle.

---
 rtl/dcache_ctrl_pkg.sv | 30 +++
 rtl/dcache_ctrl_if.sv | 40 ++++
 rtl/dcache_array.sv | 53 +++++
 rtl/dcache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_pkg
// Purpose : shared definitions for the direct-mapped write-through data cache.
//           FSM state encoding and helpers that split a byte address into
//           offset / word / index / tag fields.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package dcache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        WDONE  = 2'd3
    } state_t;

    function automatic int word_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is whatever remains above the word and index fields of the word address.
    function automatic int tag_bits(input int addr_w, input int lines, input int words);
        return addr_w - 2 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_if
// Purpose : bundles the core-side request bus and the memory-side handshake
//           bus of the data cache.
// Ports   : cpu_addr/cpu_re/cpu_we/cpu_wdata  core request
//           cpu_rdata/stall                   core response
//           mem_addr/mem_re/mem_we/mem_wdata  memory request
//           mem_rdata/mem_ready               memory response
// Modports: slave  - the cache controller
//           master - the environment (core + main memory)
// ---------------------------------------------------------------------------
interface dcache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_re;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, stall, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, stall, mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// ---------------------------------------------------------------------------
// dcache_array
// Purpose : tag / valid / data storage of the cache. Asynchronous read,
//           synchronous write, synchronous clear of all valid bits.
// Ports   : clk, rst_n            clock, synchronous active-low reset
//           index                 line selected for both read and write
//           rd_word               word read out on rd_data
//           rd_tag/rd_valid       tag and valid bit of the selected line
//           data_we/wr_word/wr_data  word write into the selected line
//           tag_we/wr_tag         tag write; also marks the line valid
// ---------------------------------------------------------------------------
module dcache_array #(
    parameter int LINES  = 32,
    parameter int WORDS  = 4,
    parameter int TAG_W  = 23,
    parameter int DATA_W = 32,
    localparam int IB    = $clog2(LINES),
    localparam int WB    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IB-1:0]     index,
    input  logic [WB-1:0]     rd_word,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              data_we,
    input  logic [WB-1:0]     wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  wr_tag
);

    logic [DATA_W-1:0] data_mem [LINES*WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid;

    assign rd_data  = data_mem[{index, rd_word}];
    assign rd_tag   = tag_mem[index];
    assign rd_valid = valid[index];

    // Data and tags carry no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[{index, wr_word}] <= wr_data;
        if (tag_we)  tag_mem[index]             <= wr_tag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      valid        <= '0;
        else if (tag_we) valid[index] <= 1'b1;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
// Purpose : direct-mapped, write-through, no-write-allocate data cache
//           between the ALU and main memory. Read hits answer in the same
//           cycle; misses and every store stall the core while a handshaked
//           memory transaction runs.
// Ports   : clk    rising-edge clock
//           rst_n  synchronous active-low reset
//           bus    dcache_ctrl_if.slave (core request/response + memory handshake)
// ---------------------------------------------------------------------------
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES  = 32,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst_n,
    dcache_ctrl_if.slave bus
);

    localparam int WB    = word_bits(WORDS);
    localparam int IB    = index_bits(LINES);
    localparam int TAG_W = tag_bits(ADDR_W, LINES, WORDS);
    localparam int WA_W  = ADDR_W - 2;

    state_t            state, next_state;
    logic [WA_W-1:0]   lat_waddr, look_waddr;
    logic [DATA_W-1:0] lat_wdata;
    logic [WB-1:0]     cnt, look_word, wr_word;
    logic [IB-1:0]     look_index;
    logic [TAG_W-1:0]  look_tag, rd_tag;
    logic [DATA_W-1:0] rd_data, wr_data;
    logic              rd_valid, hit, latch_req, data_we, tag_we;
    logic              stall, mem_re, mem_we;
    logic [DATA_W-1:0] cpu_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              unused_offset;

    // Byte offset is meaningless for word accesses.
    assign unused_offset = ^bus.cpu_addr[1:0];

    // While idle the array is looked up with the live core address; during a
    // transaction it follows the latched address so the request may change.
    assign look_waddr = (state == IDLE) ? bus.cpu_addr[ADDR_W-1:2] : lat_waddr;
    assign look_word  = look_waddr[WB-1:0];
    assign look_index = look_waddr[WB +: IB];
    assign look_tag   = look_waddr[WA_W-1 -: TAG_W];
    assign hit        = rd_valid && (rd_tag == look_tag);

    dcache_array #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .index    (look_index),
        .rd_word  (look_word),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .data_we  (data_we),
        .wr_word  (wr_word),
        .wr_data  (wr_data),
        .tag_we   (tag_we),
        .wr_tag   (look_tag)
    );

    // Next state and all outputs. Memory outputs depend only on registered
    // state, so they hold steady while a request is pending.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        cpu_rdata  = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        latch_req  = 1'b0;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        wr_word    = look_word;
        wr_data    = bus.mem_rdata;
        case (state)
            IDLE: begin
                if (bus.cpu_we) begin
                    stall      = 1'b1;
                    latch_req  = 1'b1;
                    next_state = WRITE;
                end else if (bus.cpu_re) begin
                    if (hit) begin
                        cpu_rdata = rd_data;
                    end else begin
                        stall      = 1'b1;
                        latch_req  = 1'b1;
                        next_state = REFILL;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_re   = 1'b1;
                mem_addr = {lat_waddr[WA_W-1:WB], cnt, 2'b00};
                if (bus.mem_ready) begin
                    data_we = 1'b1;
                    wr_word = cnt;
                    // Tag and valid go in with the last beat, so an aborted
                    // refill never leaves a half-filled line marked valid.
                    if (cnt == WB'(WORDS - 1)) begin
                        tag_we     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            WRITE: begin
                stall     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {lat_waddr, 2'b00};
                mem_wdata = lat_wdata;
                if (bus.mem_ready) begin
                    data_we    = hit;
                    wr_data    = lat_wdata;
                    next_state = WDONE;
                end
            end
            WDONE: begin
                // One unstalled cycle lets the core retire the store without re-issuing it.
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (latch_req)
                cnt <= '0;
            else if (state == REFILL && bus.mem_ready)
                cnt <= cnt + WB'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (latch_req) begin
            lat_waddr <= bus.cpu_addr[ADDR_W-1:2];
            lat_wdata <= bus.cpu_wdata;
        end
    end

    assign bus.cpu_rdata = cpu_rdata;
    assign bus.stall     = stall;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_re    = mem_re;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl
// Purpose : directed self-checking bench for dcache_ctrl. A small memory
//           model answers each request with mem_ready every second cycle.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl;

    localparam int LINES = 32;
    localparam int WORDS = 4;
    localparam logic [31:0] ALIAS = 32'(LINES * WORDS * 4);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dcache_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dcache_ctrl #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Main memory model state
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] rd_log [$];
    int          rd_beats = 0;
    int          wr_beats = 0;
    int          wait_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    function automatic logic [31:0] memValue(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'h5000_0000 | a;
    endfunction

    // Memory: one idle cycle, then a one-cycle ready strobe, repeated.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        mem_model[32'h100] = 32'h0000_00A0;
        mem_model[32'h104] = 32'h0000_00A1;
        mem_model[32'h108] = 32'h0000_00A2;
        mem_model[32'h10C] = 32'h0000_00A3;
        forever begin
            @(negedge clk);
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                wait_cnt = 1;
            end else if (bus.mem_re || bus.mem_we) begin
                if (wait_cnt >= 1) begin
                    bus.mem_ready = 1'b1;
                    wait_cnt = 0;
                    if (bus.mem_re) begin
                        bus.mem_rdata = memValue(bus.mem_addr);
                        rd_log.push_back(bus.mem_addr);
                        rd_beats++;
                    end else begin
                        mem_model[bus.mem_addr] = bus.mem_wdata;
                        last_wr_addr = bus.mem_addr;
                        last_wr_data = bus.mem_wdata;
                        wr_beats++;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        if (observed === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic re, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_re    = re;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    // Load held until stall drops; cycles counts negedges spent stalled.
    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                          input int exp_beats, input int exp_cycles);
        int start;
        int cycles;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, addr, '0);
        start  = rd_beats;
        cycles = 0;
        #1;
        while (bus.stall && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, " cycles"}, 32'(cycles), 32'(exp_cycles));
        checkOutput({tag, " rdata"}, bus.cpu_rdata, exp_data);
        checkOutput({tag, " beats"}, 32'(rd_beats - start), 32'(exp_beats));
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic doStore(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int start;
        int cycles;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, addr, data);
        start  = wr_beats;
        cycles = 0;
        #1;
        checkOutput({tag, " stall on issue"}, 32'(bus.stall), 32'd1);
        while (bus.stall && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
            if (cycles == 1) begin
                checkOutput({tag, " mem_we"}, 32'(bus.mem_we), 32'd1);
                checkOutput({tag, " mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
                checkOutput({tag, " mem_wdata"}, bus.mem_wdata, data);
            end
        end
        checkOutput({tag, " cycles"}, 32'(cycles), 32'd3);
        checkOutput({tag, " wr addr"}, last_wr_addr, addr & 32'hFFFF_FFFC);
        checkOutput({tag, " wr data"}, last_wr_data, data);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0);
        #1;
        checkOutput({tag, " stall after wdone"}, 32'(bus.stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, " wr count"}, 32'(wr_beats - start), 32'd1);
    endtask

    initial begin
        int q0;
        int start;
        int cycles;

        applyStimulus(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset stall", 32'(bus.stall), 32'd0);
        checkOutput("reset mem_re", 32'(bus.mem_re), 32'd0);
        checkOutput("reset mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("reset rdata", bus.cpu_rdata, 32'd0);
        rst_n = 1'b1;

        $display("[TB] test 1: cold load miss");
        q0 = rd_log.size();
        doLoad("t1 load 0x100", 32'h100, 32'h0000_00A0, 4, 9);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t1 beat%0d addr", i), rd_log[q0 + i], 32'h100 + 32'(4 * i));

        $display("[TB] test 2: load hit");
        doLoad("t2 load 0x108", 32'h108, 32'h0000_00A2, 0, 0);

        $display("[TB] test 3: store hit");
        doStore("t3 store 0x104", 32'h104, 32'hDEAD_BEEF);
        doLoad("t3 load 0x104", 32'h104, 32'hDEAD_BEEF, 0, 0);

        $display("[TB] test 4: store miss, no allocate");
        doStore("t4 store 0x2000", 32'h2000, 32'h1234_5678);
        doLoad("t4 load 0x2000", 32'h2000, 32'h1234_5678, 4, 9);
        doLoad("t4 load 0x104", 32'h104, 32'hDEAD_BEEF, 0, 0);

        $display("[TB] test 5: conflict eviction");
        doLoad("t5 load 0x100", 32'h100, 32'h0000_00A0, 0, 0);
        doLoad("t5 load alias", 32'h100 + ALIAS, 32'h5000_0000 | (32'h100 + ALIAS), 4, 9);
        doLoad("t5 reload 0x100", 32'h100, 32'h0000_00A0, 4, 9);
        doLoad("t5 load 0x104", 32'h104, 32'hDEAD_BEEF, 0, 0);

        $display("[TB] test 6: reset during refill");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h100 + ALIAS, '0);
        start  = rd_beats;
        cycles = 0;
        #1;
        while (rd_beats < start + 2 && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checkOutput("t6 cycles to beat1", 32'(cycles), 32'd4);
        checkOutput("t6 mem_re in refill", 32'(bus.mem_re), 32'd1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        checkOutput("t6 mem_re after reset", 32'(bus.mem_re), 32'd0);
        checkOutput("t6 mem_we after reset", 32'(bus.mem_we), 32'd0);
        checkOutput("t6 stall after reset", 32'(bus.stall), 32'd0);
        rst_n = 1'b1;
        doLoad("t6 load 0x100", 32'h100, 32'h0000_00A0, 4, 9);
        doLoad("t6 load 0x2000", 32'h2000, 32'h1234_5678, 4, 9);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
